// File: rtl/spu_mast_pipe_if.sv
// spu_mast_pipe_if: control, MA memory, store buffer and LSU store handshake
// signals of the SPU store sequencer. The master modport is the sequencer side
// and the slave modport is the environment (mactl, memory, LSU) side.
interface spu_mast_pipe_if #(
  parameter int LEN_W     = 6,
  parameter int MAX_OUTST = 2
);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic             spu_mactl_iss_pulse_dly;
  logic             mactl_stop;
  logic [LEN_W-1:0] mast_len;
  logic             streq_ack;
  logic             spu_mactl_perr_set;
  logic             spu_mactl_stxa_force_abort;
  logic             spu_wen_allma_stacks_ok;

  logic             spu_mast_memren;
  logic             spu_mast_maaddr_addrinc;
  logic             spu_mast_stbuf_wen;
  logic [PTR_W-1:0] spu_mast_stbuf_wptr;
  logic             spu_mast_streq;
  logic             spu_mast_mpa_addrinc;
  logic             spu_mast_done_set;
  logic             spu_mast_abort;
  logic             spu_mast_ack_err;

  modport master (
    input  spu_mactl_iss_pulse_dly, mactl_stop, mast_len, streq_ack,
           spu_mactl_perr_set, spu_mactl_stxa_force_abort, spu_wen_allma_stacks_ok,
    output spu_mast_memren, spu_mast_maaddr_addrinc, spu_mast_stbuf_wen,
           spu_mast_stbuf_wptr, spu_mast_streq, spu_mast_mpa_addrinc,
           spu_mast_done_set, spu_mast_abort, spu_mast_ack_err
  );

  modport slave (
    output spu_mactl_iss_pulse_dly, mactl_stop, mast_len, streq_ack,
           spu_mactl_perr_set, spu_mactl_stxa_force_abort, spu_wen_allma_stacks_ok,
    input  spu_mast_memren, spu_mast_maaddr_addrinc, spu_mast_stbuf_wen,
           spu_mast_stbuf_wptr, spu_mast_streq, spu_mast_mpa_addrinc,
           spu_mast_done_set, spu_mast_abort, spu_mast_ack_err
  );
endinterface

// File: rtl/spu_mast_pipe.sv
// spu_mast_pipe: store sequencer moving LEN words from MA memory to L2 via the
// store buffer, keeping up to MAX_OUTST words in flight (pipeline reads plus
// unacknowledged store requests). Aborts drain outstanding acks before done.
// Optional feature macro: SPU_MAST_DONE_DLY_EN delays done reporting by one
// extra cycle so the downstream wen ack counter sees the last store first.
module spu_mast_pipe #(
  parameter int LEN_W     = 6,
  parameter int MAX_OUTST = 2,
  parameter int RD_LAT    = 2
) (
  input logic             rclk,
  input logic             reset,
  spu_mast_pipe_if.master bus
);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int INF_W = $clog2(MAX_OUTST + RD_LAT + 2) + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
  localparam logic [INF_W-1:0] CREDITS  = INF_W'(MAX_OUTST);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d, pend_len_q, go_len;
  logic [RD_LAT:0]  pipe_q, pipe_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [PTR_W-1:0] wptr_q;
  logic [INF_W-1:0] inflight_d;
  logic             start, restart, abort_now, go, pend_q;
  logic             ack_bad, ack_ok, done_evt, done_rise;
  logic             abort_q, ack_err_q, done_q;
  logic             memren, streq, stbuf_wen;

  assign start     = bus.spu_mactl_iss_pulse_dly & bus.mactl_stop;
  assign restart   = start && (state_q == ST_DONE);
  assign abort_now = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) &&
                     (bus.spu_mactl_perr_set || bus.spu_mactl_stxa_force_abort);
  // A start seen in DONE is replayed from IDLE one cycle later via pend_q.
  assign go        = (state_q == ST_IDLE) && (start || pend_q);
  assign go_len    = pend_q ? pend_len_q : bus.mast_len;
  assign done_evt  = (state_d == ST_DONE) && (state_q != ST_DONE);

  // Output decode: reads in ISSUE, store buffer write and request from the pipe;
  // an abort cycle suppresses both the read and the request.
  always_comb begin
    memren    = (state_q == ST_ISSUE) && !abort_now;
    streq     = pipe_q[RD_LAT] && !abort_now;
    stbuf_wen = pipe_q[RD_LAT-1];
  end

  // Next values of the in-flight bookkeeping; a stray ack is flagged, not counted.
  always_comb begin
    ack_bad    = bus.streq_ack && (req_cnt_q == '0);
    ack_ok     = bus.streq_ack && !ack_bad;
    req_cnt_d  = req_cnt_q + CNT_W'(streq) - CNT_W'(ack_ok);
    rem_d      = rem_q - LEN_W'(memren);
    pipe_d     = abort_now ? '0 : {pipe_q[RD_LAT-1:0], memren};
    inflight_d = INF_W'(req_cnt_d);
    for (int i = 0; i <= RD_LAT; i++) begin
      inflight_d = inflight_d + INF_W'(pipe_d[i]);
    end
  end

  // Next-state logic: ISSUE only when next cycle has both words and a free credit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          if (go_len != '0) state_d = ST_ISSUE;
          else              state_d = ST_DONE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (abort_now)                                   state_d = ST_DRAIN;
        else if (rem_d != '0 && inflight_d < CREDITS)    state_d = ST_ISSUE;
        else if (rem_d != '0)                            state_d = ST_WAIT;
        else if (pipe_d == '0 && req_cnt_d == '0)        state_d = ST_DONE;
        else                                             state_d = ST_WAIT;
      end
      ST_DRAIN: begin
        if (req_cnt_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath: word counter, read pipe, request counter, write pointer, replay latch.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      rem_q      <= '0;
      pipe_q     <= '0;
      req_cnt_q  <= '0;
      wptr_q     <= '0;
      pend_q     <= 1'b0;
      pend_len_q <= '0;
    end else begin
      pipe_q    <= pipe_d;
      req_cnt_q <= req_cnt_d;
      rem_q     <= go ? go_len : rem_d;
      if (go)             wptr_q <= '0;
      else if (stbuf_wen) wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      if (restart) begin
        pend_q     <= 1'b1;
        pend_len_q <= bus.mast_len;
      end else if (go) begin
        pend_q <= 1'b0;
      end
    end
  end

`ifdef SPU_MAST_DONE_DLY_EN
  logic done_dly_q;

  // Extra stage so completion is reported one cycle after the DONE condition.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) done_dly_q <= 1'b0;
    else       done_dly_q <= done_evt;
  end

  assign done_rise = done_dly_q;
`else
  assign done_rise = done_evt;
`endif

  // Sticky status: abort until next accepted start, ack_err until reset, done level.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      abort_q   <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (abort_now)                                            abort_q <= 1'b1;
      else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) abort_q <= 1'b0;
      if (ack_bad) ack_err_q <= 1'b1;
      if (done_rise && !restart) done_q <= 1'b1;
      else if (start)            done_q <= 1'b0;
    end
  end

  assign bus.spu_mast_memren         = memren;
  assign bus.spu_mast_maaddr_addrinc = memren;
  assign bus.spu_mast_stbuf_wen      = stbuf_wen;
  assign bus.spu_mast_stbuf_wptr     = wptr_q;
  assign bus.spu_mast_streq          = streq;
  assign bus.spu_mast_mpa_addrinc    = streq;
  assign bus.spu_mast_done_set       = done_q & bus.spu_wen_allma_stacks_ok;
  assign bus.spu_mast_abort          = abort_q;
  assign bus.spu_mast_ack_err        = ack_err_q;
endmodule

// File: tb/tb_spu_mast_pipe.sv
// tb_spu_mast_pipe: directed bench for spu_mast_pipe with default parameters.
// A per-cycle vector table covers a single-word store; hand-written sequences
// cover credit stalls, zero length, abort drain, stray acks and mid-run reset.
module tb_spu_mast_pipe;
  localparam int LEN_W     = 6;
  localparam int MAX_OUTST = 2;
  localparam int RD_LAT    = 2;
`ifdef SPU_MAST_DONE_DLY_EN
  localparam int DONE_DLY = 2;
`else
  localparam int DONE_DLY = 1;
`endif

  typedef struct {
    logic             start;
    logic [LEN_W-1:0] len;
    logic             ack;
    logic             exp_memren;
    logic             exp_wen;
    logic             exp_streq;
    logic             exp_done;
  } vec_t;

  logic rclk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   memren_cnt = 0;
  int   streq_cnt = 0;
  int   wlog[$];
  vec_t vecs[11];

  spu_mast_pipe_if #(.LEN_W(LEN_W), .MAX_OUTST(MAX_OUTST)) bus ();

  spu_mast_pipe #(.LEN_W(LEN_W), .MAX_OUTST(MAX_OUTST), .RD_LAT(RD_LAT)) dut (
    .rclk  (rclk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  // Event monitor: counts reads and requests, logs the write pointer of each write.
  always @(negedge rclk) begin
    if (!reset) begin
      if (bus.spu_mast_memren) memren_cnt <= memren_cnt + 1;
      if (bus.spu_mast_streq)  streq_cnt  <= streq_cnt + 1;
      if (bus.spu_mast_stbuf_wen) wlog.push_back(int'(bus.spu_mast_stbuf_wptr));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic s, input int l, input logic a, input logic m,
                              input logic w, input logic q, input logic d);
    vec_t v;
    v.start = s; v.len = LEN_W'(l); v.ack = a;
    v.exp_memren = m; v.exp_wen = w; v.exp_streq = q; v.exp_done = d;
    return v;
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.spu_mactl_iss_pulse_dly = v.start;
    bus.mactl_stop              = v.start;
    bus.mast_len                = v.len;
    bus.streq_ack               = v.ack;
  endtask

  task automatic pulseStart(input int len);
    bus.spu_mactl_iss_pulse_dly = 1'b1;
    bus.mactl_stop              = 1'b1;
    bus.mast_len                = LEN_W'(len);
    tick();
    bus.spu_mactl_iss_pulse_dly = 1'b0;
    bus.mactl_stop              = 1'b0;
  endtask

  task automatic pulseAck();
    bus.streq_ack = 1'b1;
    tick();
    bus.streq_ack = 1'b0;
  endtask

  // Ack in the current cycle A; done_set must appear exactly at A+DONE_DLY.
  task automatic ackAndCheckDone(input string name);
    bus.streq_ack = 1'b1;
    #3 checkOutput({name, "_in_ack_cycle"}, bus.spu_mast_done_set, 0);
    tick();
    bus.streq_ack = 1'b0;
    for (int d = 1; d < DONE_DLY; d++) begin
      #3 checkOutput({name, "_early"}, bus.spu_mast_done_set, 0);
      tick();
    end
    #3 checkOutput({name, "_rise"}, bus.spu_mast_done_set, 1);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_memren"}, bus.spu_mast_memren, 0);
    checkOutput({name, "_streq"}, bus.spu_mast_streq, 0);
    checkOutput({name, "_wen"}, bus.spu_mast_stbuf_wen, 0);
    checkOutput({name, "_wptr"}, int'(bus.spu_mast_stbuf_wptr), 0);
    checkOutput({name, "_done"}, bus.spu_mast_done_set, 0);
    checkOutput({name, "_abort"}, bus.spu_mast_abort, 0);
    checkOutput({name, "_ack_err"}, bus.spu_mast_ack_err, 0);
  endtask

  initial begin
    int mb, sb, wb, g, seen;
    // Single word, start at cycle 0 edge, ack 3 cycles after the request.
    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 1, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, DONE_DLY == 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1);

    reset = 1'b1;
    bus.spu_mactl_iss_pulse_dly    = 1'b0;
    bus.mactl_stop                 = 1'b0;
    bus.mast_len                   = '0;
    bus.streq_ack                  = 1'b0;
    bus.spu_mactl_perr_set         = 1'b0;
    bus.spu_mactl_stxa_force_abort = 1'b0;
    bus.spu_wen_allma_stacks_ok    = 1'b1;
    repeat (2) @(posedge rclk);
    #1 checkAllZero("reset");
    reset = 1'b0;
    tick();

    $display("[TB] single-word vector table");
    for (int k = 0; k < 11; k++) begin
      applyStimulus(vecs[k]);
      #3;
      checkOutput($sformatf("vec%0d_memren", k), bus.spu_mast_memren, vecs[k].exp_memren);
      checkOutput($sformatf("vec%0d_addrinc", k), bus.spu_mast_maaddr_addrinc, vecs[k].exp_memren);
      checkOutput($sformatf("vec%0d_wen", k), bus.spu_mast_stbuf_wen, vecs[k].exp_wen);
      checkOutput($sformatf("vec%0d_streq", k), bus.spu_mast_streq, vecs[k].exp_streq);
      checkOutput($sformatf("vec%0d_mpa", k), bus.spu_mast_mpa_addrinc, vecs[k].exp_streq);
      checkOutput($sformatf("vec%0d_done", k), bus.spu_mast_done_set, vecs[k].exp_done);
      tick();
    end

    $display("[TB] issue pulse without store select is ignored");
    bus.spu_mactl_iss_pulse_dly = 1'b1;
    bus.mast_len = LEN_W'(3);
    tick();
    bus.spu_mactl_iss_pulse_dly = 1'b0;
    waitCycles(2);
    #3 checkOutput("nostop_done_held", bus.spu_mast_done_set, 1);
    checkOutput("nostop_memren", bus.spu_mast_memren, 0);
    tick();

    $display("[TB] len=5 credit stall and ack release");
    mb = memren_cnt; sb = streq_cnt; wb = wlog.size();
    bus.spu_mactl_iss_pulse_dly = 1'b1;
    bus.mactl_stop = 1'b1;
    bus.mast_len = LEN_W'(5);
    tick();
    bus.spu_mactl_iss_pulse_dly = 1'b0;
    bus.mactl_stop = 1'b0;
    #3 checkOutput("A_done_cleared", bus.spu_mast_done_set, 0);
    checkOutput("A_idle_no_memren", bus.spu_mast_memren, 0);
    tick();
    #3 checkOutput("A_replay_memren", bus.spu_mast_memren, 1);
    tick();
    waitCycles(12);
    checkOutput("A_stall_memren", memren_cnt - mb, 2);
    checkOutput("A_stall_streq", streq_cnt - sb, 2);
    for (int i = 0; i < 3; i++) begin
      pulseAck();
      waitCycles(7);
      checkOutput($sformatf("A_ack%0d_memren", i), memren_cnt - mb, 3 + i);
    end
    checkOutput("A_streq_total", streq_cnt - sb, 5);
    pulseAck();
    waitCycles(3);
    #3 checkOutput("A_done_before_last_ack", bus.spu_mast_done_set, 0);
    ackAndCheckDone("A_done");
    tick();
    checkOutput("A_wptr_count", wlog.size() - wb, 5);
    for (int i = 0; i < 5; i++) begin
      if (wb + i < wlog.size()) checkOutput($sformatf("A_wptr%0d", i), wlog[wb + i], i % 2);
    end

    $display("[TB] zero length with stacks not ok");
    mb = memren_cnt; sb = streq_cnt;
    bus.spu_wen_allma_stacks_ok = 1'b0;
    pulseStart(0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #3 if (bus.spu_mast_done_set) seen = 1;
      tick();
    end
    checkOutput("B_done_masked", seen, 0);
    checkOutput("B_no_memren", memren_cnt - mb, 0);
    checkOutput("B_no_streq", streq_cnt - sb, 0);
    bus.spu_wen_allma_stacks_ok = 1'b1;
    #3 checkOutput("B_done_unmasked", bus.spu_mast_done_set, 1);
    tick();

    $display("[TB] abort with two requests outstanding");
    mb = memren_cnt; sb = streq_cnt;
    pulseStart(6);
    g = 0;
    while ((streq_cnt - sb) < 2 && g < 30) begin tick(); g++; end
    checkOutput("C_two_streqs", streq_cnt - sb, 2);
    checkOutput("C_two_memrens", memren_cnt - mb, 2);
    pulseAck();
    g = 0;
    while ((streq_cnt - sb) < 3 && g < 30) begin tick(); g++; end
    checkOutput("C_third_streq", streq_cnt - sb, 3);
    checkOutput("C_third_memren", memren_cnt - mb, 3);
    tick();
    bus.spu_mactl_stxa_force_abort = 1'b1;
    tick();
    bus.spu_mactl_stxa_force_abort = 1'b0;
    waitCycles(10);
    checkOutput("C_post_abort_memren", memren_cnt - mb, 3);
    checkOutput("C_post_abort_streq", streq_cnt - sb, 3);
    #3 checkOutput("C_abort_flag", bus.spu_mast_abort, 1);
    checkOutput("C_drain_no_done", bus.spu_mast_done_set, 0);
    tick();
    pulseAck();
    waitCycles(4);
    #3 checkOutput("C_one_ack_no_done", bus.spu_mast_done_set, 0);
    checkOutput("C_ack_no_memren", memren_cnt - mb, 3);
    ackAndCheckDone("C_done");
    checkOutput("C_abort_sticky", bus.spu_mast_abort, 1);
    tick();

    $display("[TB] ack with nothing outstanding");
    #3 checkOutput("D_ack_err_clear", bus.spu_mast_ack_err, 0);
    tick();
    pulseAck();
    #3 checkOutput("D_ack_err_set", bus.spu_mast_ack_err, 1);
    checkOutput("D_done_kept", bus.spu_mast_done_set, 1);
    tick();

    $display("[TB] restart after abort and stray ack");
    mb = memren_cnt; sb = streq_cnt;
    pulseStart(1);
    #3 checkOutput("E_abort_cleared", bus.spu_mast_abort, 0);
    checkOutput("E_ack_err_sticky", bus.spu_mast_ack_err, 1);
    tick();
    #3 checkOutput("E_replay_memren", bus.spu_mast_memren, 1);
    tick();
    g = 0;
    while ((streq_cnt - sb) < 1 && g < 20) begin tick(); g++; end
    checkOutput("E_streq", streq_cnt - sb, 1);
    ackAndCheckDone("E_done");
    tick();

    $display("[TB] reset mid-transfer then fresh start");
    pulseStart(5);
    waitCycles(5);
    reset = 1'b1;
    #1 checkAllZero("F_reset");
    tick();
    tick();
    reset = 1'b0;
    mb = memren_cnt; sb = streq_cnt;
    bus.spu_mactl_iss_pulse_dly = 1'b1;
    bus.mactl_stop = 1'b1;
    bus.mast_len = LEN_W'(1);
    #3 checkOutput("F_c0_memren", bus.spu_mast_memren, 0);
    tick();
    bus.spu_mactl_iss_pulse_dly = 1'b0;
    bus.mactl_stop = 1'b0;
    #3 checkOutput("F_c1_memren", bus.spu_mast_memren, 1);
    waitCycles(2);
    #3 checkOutput("F_c3_wen", bus.spu_mast_stbuf_wen, 1);
    tick();
    #3 checkOutput("F_c4_streq", bus.spu_mast_streq, 1);
    waitCycles(3);
    ackAndCheckDone("F_done");
    waitCycles(3);
    checkOutput("F_memren_total", memren_cnt - mb, 1);
    checkOutput("F_streq_total", streq_cnt - sb, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
